// File: rtl/pipelined_divider_rs_pkg.sv
// Shared constants and elaboration helpers for the pipelined sign-magnitude restoring divider.
package pipelined_divider_rs_pkg;
    localparam int ROUND_TRUNC     = 0;
    localparam int ROUND_HALF_AWAY = 1;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic bit split_is_legal(input int width, input int bits_per_stage);
        return (bits_per_stage > 0) && ((width % bits_per_stage) == 0);
    endfunction
endpackage

// File: rtl/pipelined_divider_rs_stage.sv
// One iterate stage: BITS_PER_STAGE combinational restoring steps followed by a
// register that only moves when the whole pipeline advances.
module pipelined_divider_rs_stage
    import pipelined_divider_rs_pkg::*;
#(
    parameter int DIVIDEND_W     = 16,
    parameter int DIVISOR_W      = 8,
    parameter int TAG_W          = 8,
    parameter int BITS_PER_STAGE = 1,
    parameter int STAGE_INDEX    = 0
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  adv,
    input  logic                  prev_valid,
    input  logic [TAG_W-1:0]      prev_tag,
    input  logic                  prev_neg,
    input  logic                  prev_dz,
    input  logic [DIVISOR_W-1:0]  prev_divisor,
    input  logic [DIVIDEND_W-1:0] prev_mag,
    input  logic [DIVISOR_W-1:0]  prev_rem,
    input  logic [DIVIDEND_W-1:0] prev_quot,
    output logic                  valid,
    output logic [TAG_W-1:0]      tag,
    output logic                  neg,
    output logic                  dz,
    output logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] mag,
    output logic [DIVISOR_W-1:0]  rem,
    output logic [DIVIDEND_W-1:0] quot
);
    // Magnitude bits are consumed MSB first; this stage owns a fixed slice of them.
    localparam int FIRST_BIT = DIVIDEND_W - 1 - STAGE_INDEX * BITS_PER_STAGE;

    logic [DIVISOR_W-1:0]      step_rem [0:BITS_PER_STAGE];
    logic [BITS_PER_STAGE-1:0] step_bits;
    logic [DIVIDEND_W-1:0]     next_quot;

    assign step_rem[0] = prev_rem;

    for (genvar j = 0; j < BITS_PER_STAGE; j++) begin : g_step
        logic [DIVISOR_W:0] trial;
        assign trial = {step_rem[j], prev_mag[FIRST_BIT - j]};
        assign step_bits[BITS_PER_STAGE - 1 - j] = (trial >= {1'b0, prev_divisor});
        // The difference is always below the divisor, so it fits the narrow width.
        assign step_rem[j + 1] = step_bits[BITS_PER_STAGE - 1 - j]
                                 ? (trial[DIVISOR_W-1:0] - prev_divisor)
                                 : trial[DIVISOR_W-1:0];
    end

    always_comb begin
        next_quot = prev_quot;
        next_quot[FIRST_BIT -: BITS_PER_STAGE] = step_bits;
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            valid <= 1'b0;
        end else if (adv) begin
            valid <= prev_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (adv) begin
            tag     <= prev_tag;
            neg     <= prev_neg;
            dz      <= prev_dz;
            divisor <= prev_divisor;
            mag     <= prev_mag;
            rem     <= step_rem[BITS_PER_STAGE];
            quot    <= next_quot;
        end
    end
endmodule

// File: rtl/pipelined_divider_rs.sv
// Pipelined signed/unsigned divider for the JPEG quantisation path: input stage,
// DIVIDEND_W/BITS_PER_STAGE iterate stages, then rounding/sign output stage.
module pipelined_divider_rs
    import pipelined_divider_rs_pkg::*;
#(
    parameter int DIVIDEND_W     = 16,
    parameter int DIVISOR_W      = 8,
    parameter int TAG_W          = 8,
    parameter int BITS_PER_STAGE = 1,
    parameter int ROUND_MODE     = ROUND_TRUNC
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_W-1:0]      out_tag,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVIDEND_W-1:0] remainder,
    output logic                  div_zero
);
    localparam int STAGES = DIVIDEND_W / BITS_PER_STAGE;

    if (!split_is_legal(DIVIDEND_W, BITS_PER_STAGE)) begin : g_illegal_split
        $error("BITS_PER_STAGE must evenly divide DIVIDEND_W");
    end

    logic adv;

    logic                  chain_valid   [0:STAGES];
    logic [TAG_W-1:0]      chain_tag     [0:STAGES];
    logic                  chain_neg     [0:STAGES];
    logic                  chain_dz      [0:STAGES];
    logic [DIVISOR_W-1:0]  chain_divisor [0:STAGES];
    logic [DIVIDEND_W-1:0] chain_mag     [0:STAGES];
    logic [DIVISOR_W-1:0]  chain_rem     [0:STAGES];
    logic [DIVIDEND_W-1:0] chain_quot    [0:STAGES];

    logic                  s0_valid;
    logic [TAG_W-1:0]      s0_tag;
    logic                  s0_neg;
    logic                  s0_dz;
    logic [DIVISOR_W-1:0]  s0_divisor;
    logic [DIVIDEND_W-1:0] s0_mag;

    // A single stall signal freezes every register, so in-flight order is preserved.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_ff @(posedge clock) begin
        if (nreset) begin
            s0_valid <= 1'b0;
        end else if (adv) begin
            s0_valid <= in_valid;
        end
    end

    // Negating the most negative dividend wraps to 2^(W-1), which is its true magnitude.
    always_ff @(posedge clock) begin
        if (adv) begin
            s0_tag     <= in_tag;
            s0_neg     <= dividend[DIVIDEND_W-1];
            s0_mag     <= dividend[DIVIDEND_W-1] ? -dividend : dividend;
            s0_dz      <= (divisor == '0);
            s0_divisor <= divisor;
        end
    end

    assign chain_valid[0]   = s0_valid;
    assign chain_tag[0]     = s0_tag;
    assign chain_neg[0]     = s0_neg;
    assign chain_dz[0]      = s0_dz;
    assign chain_divisor[0] = s0_divisor;
    assign chain_mag[0]     = s0_mag;
    assign chain_rem[0]     = '0;
    assign chain_quot[0]    = '0;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipelined_divider_rs_stage #(
            .DIVIDEND_W    (DIVIDEND_W),
            .DIVISOR_W     (DIVISOR_W),
            .TAG_W         (TAG_W),
            .BITS_PER_STAGE(BITS_PER_STAGE),
            .STAGE_INDEX   (g)
        ) u_stage (
            .clock        (clock),
            .nreset       (nreset),
            .adv          (adv),
            .prev_valid   (chain_valid[g]),
            .prev_tag     (chain_tag[g]),
            .prev_neg     (chain_neg[g]),
            .prev_dz      (chain_dz[g]),
            .prev_divisor (chain_divisor[g]),
            .prev_mag     (chain_mag[g]),
            .prev_rem     (chain_rem[g]),
            .prev_quot    (chain_quot[g]),
            .valid        (chain_valid[g + 1]),
            .tag          (chain_tag[g + 1]),
            .neg          (chain_neg[g + 1]),
            .dz           (chain_dz[g + 1]),
            .divisor      (chain_divisor[g + 1]),
            .mag          (chain_mag[g + 1]),
            .rem          (chain_rem[g + 1]),
            .quot         (chain_quot[g + 1])
        );
    end

    logic [DIVIDEND_W-1:0] q_mag;
    logic [DIVIDEND_W-1:0] r_mag;
    logic [DIVIDEND_W-1:0] q_next;
    logic [DIVIDEND_W-1:0] r_next;
    logic                  rounded;

    // Rounding up moves the quotient past the exact value, so the remainder changes sign
    // to keep dividend = quotient*divisor + remainder.
    always_comb begin
        q_mag   = chain_quot[STAGES];
        r_mag   = DIVIDEND_W'(chain_rem[STAGES]);
        rounded = 1'b0;
        if ((ROUND_MODE == ROUND_HALF_AWAY) &&
            ({chain_rem[STAGES], 1'b0} >= {1'b0, chain_divisor[STAGES]})) begin
            q_mag   = q_mag + DIVIDEND_W'(1);
            r_mag   = DIVIDEND_W'(chain_divisor[STAGES] - chain_rem[STAGES]);
            rounded = 1'b1;
        end
        q_next = chain_neg[STAGES] ? -q_mag : q_mag;
        r_next = (chain_neg[STAGES] ^ rounded) ? -r_mag : r_mag;
        if (chain_dz[STAGES]) begin
            q_next = chain_neg[STAGES] ? {1'b1, {(DIVIDEND_W-1){1'b0}}}
                                       : {1'b0, {(DIVIDEND_W-1){1'b1}}};
            r_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (adv) begin
            out_valid <= chain_valid[STAGES];
            out_tag   <= chain_tag[STAGES];
            quotient  <= q_next;
            remainder <= r_next;
            div_zero  <= chain_valid[STAGES] & chain_dz[STAGES];
        end
    end
endmodule

// File: tb/tb_pipelined_divider_rs.sv
// Self-checking bench: four divider configurations (truncate/round, 1/2/4 bits per stage)
// checked against an integer-arithmetic reference model.
module tb_pipelined_divider_rs;
    localparam int NDUT = 4;

    logic        clock;
    logic        nreset;
    logic        in_valid_a  [NDUT];
    logic        in_ready_a  [NDUT];
    logic [7:0]  in_tag_a    [NDUT];
    logic [15:0] dividend_a  [NDUT];
    logic [7:0]  divisor_a   [NDUT];
    logic        out_valid_a [NDUT];
    logic        out_ready_a [NDUT];
    logic [7:0]  out_tag_a   [NDUT];
    logic [15:0] quotient_a  [NDUT];
    logic [15:0] remainder_a [NDUT];
    logic        div_zero_a  [NDUT];

    int vectors = 0;
    int miscompares = 0;

    pipelined_divider_rs #(.BITS_PER_STAGE(1), .ROUND_MODE(0)) u_dut0 (
        .clock(clock), .nreset(nreset), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .in_tag(in_tag_a[0]), .dividend(dividend_a[0]), .divisor(divisor_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .out_tag(out_tag_a[0]),
        .quotient(quotient_a[0]), .remainder(remainder_a[0]), .div_zero(div_zero_a[0]));
    pipelined_divider_rs #(.BITS_PER_STAGE(1), .ROUND_MODE(1)) u_dut1 (
        .clock(clock), .nreset(nreset), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .in_tag(in_tag_a[1]), .dividend(dividend_a[1]), .divisor(divisor_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .out_tag(out_tag_a[1]),
        .quotient(quotient_a[1]), .remainder(remainder_a[1]), .div_zero(div_zero_a[1]));
    pipelined_divider_rs #(.BITS_PER_STAGE(2), .ROUND_MODE(1)) u_dut2 (
        .clock(clock), .nreset(nreset), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .in_tag(in_tag_a[2]), .dividend(dividend_a[2]), .divisor(divisor_a[2]),
        .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]), .out_tag(out_tag_a[2]),
        .quotient(quotient_a[2]), .remainder(remainder_a[2]), .div_zero(div_zero_a[2]));
    pipelined_divider_rs #(.BITS_PER_STAGE(4), .ROUND_MODE(0)) u_dut3 (
        .clock(clock), .nreset(nreset), .in_valid(in_valid_a[3]), .in_ready(in_ready_a[3]),
        .in_tag(in_tag_a[3]), .dividend(dividend_a[3]), .divisor(divisor_a[3]),
        .out_valid(out_valid_a[3]), .out_ready(out_ready_a[3]), .out_tag(out_tag_a[3]),
        .quotient(quotient_a[3]), .remainder(remainder_a[3]), .div_zero(div_zero_a[3]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit dut_rounds(input int d);
        return (d == 1) || (d == 2);
    endfunction

    function automatic int dut_latency(input int d);
        int bps;
        bps = (d == 2) ? 2 : ((d == 3) ? 4 : 1);
        return 16 / bps + 2;
    endfunction

    // Reference: exact integer division truncated toward zero, optionally nudged half away.
    function automatic void ref_divide(input int a, input int b, input bit rnd,
                                       output logic [15:0] q, output logic [15:0] r,
                                       output logic dz);
        int qi;
        int ri;
        if (b == 0) begin
            dz = 1'b1;
            qi = (a < 0) ? -32768 : 32767;
            ri = 0;
        end else begin
            dz = 1'b0;
            qi = a / b;
            ri = a - qi * b;
            if (rnd && (2 * ((ri < 0) ? -ri : ri) >= b)) begin
                qi = qi + ((a < 0) ? -1 : 1);
                ri = a - qi * b;
            end
        end
        q = 16'(qi);
        r = 16'(ri);
    endfunction

    task automatic run_op(input int d, input logic [15:0] a, input logic [7:0] b,
                          input logic [7:0] tag, output logic [15:0] q,
                          output logic [15:0] r, output logic dz, output logic [7:0] t,
                          output int lat);
        int waited;
        waited = 0;
        @(posedge clock); #1;
        out_ready_a[d] = 1'b1;
        in_valid_a[d]  = 1'b1;
        dividend_a[d]  = a;
        divisor_a[d]   = b;
        in_tag_a[d]    = tag;
        while (in_ready_a[d] !== 1'b1 && waited < 50) begin
            @(posedge clock); #1;
            waited++;
        end
        @(posedge clock); #1;
        in_valid_a[d] = 1'b0;
        lat = 1;
        while (out_valid_a[d] !== 1'b1 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        if (out_valid_a[d] !== 1'b1) lat = -1;
        q  = quotient_a[d];
        r  = remainder_a[d];
        dz = div_zero_a[d];
        t  = out_tag_a[d];
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid_a[d] = 1'b0; in_tag_a[d] = '0; dividend_a[d] = '0;
            divisor_a[d] = '0; out_ready_a[d] = 1'b1;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            vectors++;
            if (out_valid_a[d] !== 1'b0 || div_zero_a[d] !== 1'b0 || quotient_a[d] !== 16'h0 ||
                remainder_a[d] !== 16'h0 || out_tag_a[d] !== 8'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs dut%0d: got valid=%b dz=%b q=%h r=%h tag=%h, expected all zero",
                         d, out_valid_a[d], div_zero_a[d], quotient_a[d], remainder_a[d], out_tag_a[d]);
            end
            vectors++;
            if (in_ready_a[d] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL reset_in_ready dut%0d: got %b expected 1", d, in_ready_a[d]);
            end
        end
        @(negedge clock);
        nreset = 1'b0;
    endtask

    task automatic test_truncate();
        logic [15:0] q, r; logic dz; logic [7:0] t; int lat;
        for (int d = 0; d < NDUT; d++) begin
            if (d == 1) continue;
            run_op(d, 16'd100, 8'd7, 8'h11, q, r, dz, t, lat);
            vectors++;
            if (q !== 16'd14 || r !== 16'd2 || dz !== 1'b0 || t !== 8'h11) begin
                miscompares++;
                $display("[TB] FAIL t1_100_div_7 dut%0d: got q=%0d r=%0d dz=%b tag=%h, expected q=14 r=2 dz=0 tag=11",
                         d, $signed(q), $signed(r), dz, t);
            end
            vectors++;
            if (lat !== dut_latency(d)) begin
                miscompares++;
                $display("[TB] FAIL t1_latency dut%0d: got %0d cycles expected %0d", d, lat, dut_latency(d));
            end
        end
    endtask

    task automatic test_sign_round();
        logic [15:0] q, r; logic dz; logic [7:0] t; int lat;
        logic [15:0] cases_a [4] = '{-16'sd100, -16'sd100, 16'd100, 16'd99};
        int          cases_d [4] = '{0, 1, 1, 1};
        logic [15:0] want_q  [4] = '{-16'sd12, -16'sd13, 16'd13, 16'd12};
        logic [15:0] want_r  [4] = '{-16'sd4, 16'd4, -16'sd4, 16'd3};
        for (int i = 0; i < 4; i++) begin
            run_op(cases_d[i], cases_a[i], 8'd8, 8'(i + 32), q, r, dz, t, lat);
            vectors++;
            if (q !== want_q[i] || r !== want_r[i] || dz !== 1'b0 || t !== 8'(i + 32)) begin
                miscompares++;
                $display("[TB] FAIL t2_sign_round case%0d: got q=%0d r=%0d dz=%b tag=%h, expected q=%0d r=%0d dz=0 tag=%h",
                         i, $signed(q), $signed(r), dz, t, $signed(want_q[i]), $signed(want_r[i]), 8'(i + 32));
            end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] q, r; logic dz; logic [7:0] t; int lat;
        logic [15:0] cases_a [4] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h8000};
        logic [7:0]  cases_b [4] = '{8'd1, 8'd255, 8'd255, 8'd1};
        int          cases_d [4] = '{0, 0, 0, 1};
        logic [15:0] want_q  [4] = '{16'h8000, 16'd128, -16'sd128, 16'h8000};
        logic [15:0] want_r  [4] = '{16'd0, 16'd127, -16'sd128, 16'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(cases_d[i], cases_a[i], cases_b[i], 8'(i), q, r, dz, t, lat);
            vectors++;
            if (q !== want_q[i] || r !== want_r[i] || dz !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL t3_extreme case%0d: got q=%0d r=%0d dz=%b, expected q=%0d r=%0d dz=0",
                         i, $signed(q), $signed(r), dz, $signed(want_q[i]), $signed(want_r[i]));
            end
        end
    endtask

    task automatic test_div_zero();
        logic [15:0] q, r; logic dz; logic [7:0] t; int lat;
        logic [15:0] cases_a [4] = '{16'd500, -16'sd5, 16'd9, 16'd500};
        logic [7:0]  cases_b [4] = '{8'd0, 8'd0, 8'd3, 8'd0};
        int          cases_d [4] = '{0, 0, 0, 1};
        logic [15:0] want_q  [4] = '{16'h7FFF, 16'h8000, 16'd3, 16'h7FFF};
        logic        want_dz [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(cases_d[i], cases_a[i], cases_b[i], 8'(i + 64), q, r, dz, t, lat);
            vectors++;
            if (q !== want_q[i] || r !== 16'd0 || dz !== want_dz[i] || t !== 8'(i + 64)) begin
                miscompares++;
                $display("[TB] FAIL t4_div_zero case%0d: got q=%0d r=%0d dz=%b tag=%h, expected q=%0d r=0 dz=%b tag=%h",
                         i, $signed(q), $signed(r), dz, t, $signed(want_q[i]), want_dz[i], 8'(i + 64));
            end
        end
    endtask

    task automatic test_back_to_back(input int d, input int n_ops);
        logic [15:0] op_a [64];
        logic [7:0]  op_b [64];
        logic [7:0]  op_t [64];
        logic [15:0] exp_q [64];
        logic [15:0] exp_r [64];
        logic        exp_dz [64];
        int sent, got, cycle, stall_left, s1, s2;
        bit extra;
        for (int i = 0; i < n_ops; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = (i % 13 == 5) ? 8'd0 : 8'($urandom_range(1, 255));
            op_t[i] = 8'($urandom);
            ref_divide(int'($signed(op_a[i])), int'(op_b[i]), dut_rounds(d),
                       exp_q[i], exp_r[i], exp_dz[i]);
        end
        sent = 0; got = 0; cycle = 0; stall_left = 0;
        s1 = $urandom_range(3, 20);
        s2 = $urandom_range(25, 45);
        @(posedge clock); #1;
        while (got < n_ops && cycle < 2000) begin
            if (cycle == s1 || cycle == s2) stall_left = 5;
            out_ready_a[d] = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (sent < n_ops) begin
                in_valid_a[d] = 1'b1;
                dividend_a[d] = op_a[sent];
                divisor_a[d]  = op_b[sent];
                in_tag_a[d]   = op_t[sent];
            end else begin
                in_valid_a[d] = 1'b0;
            end
            @(negedge clock);
            vectors++;
            if (in_ready_a[d] !== (!out_valid_a[d] || out_ready_a[d])) begin
                miscompares++;
                $display("[TB] FAIL t5_in_ready dut%0d cycle %0d: got %b expected %b",
                         d, cycle, in_ready_a[d], !out_valid_a[d] || out_ready_a[d]);
            end
            if (out_valid_a[d] === 1'b1 && out_ready_a[d]) begin
                vectors++;
                if (got >= n_ops) begin
                    miscompares++;
                    $display("[TB] FAIL t5_extra_result dut%0d: got result %0d expected only %0d", d, got, n_ops);
                end else if (quotient_a[d] !== exp_q[got] || remainder_a[d] !== exp_r[got] ||
                             div_zero_a[d] !== exp_dz[got] || out_tag_a[d] !== op_t[got]) begin
                    miscompares++;
                    $display("[TB] FAIL t5_result dut%0d op%0d (%0d/%0d): got q=%0d r=%0d dz=%b tag=%h, expected q=%0d r=%0d dz=%b tag=%h",
                             d, got, $signed(op_a[got]), op_b[got], $signed(quotient_a[d]),
                             $signed(remainder_a[d]), div_zero_a[d], out_tag_a[d],
                             $signed(exp_q[got]), $signed(exp_r[got]), exp_dz[got], op_t[got]);
                end
                got++;
            end
            if (in_valid_a[d] && in_ready_a[d]) sent++;
            @(posedge clock); #1;
            cycle++;
        end
        in_valid_a[d]  = 1'b0;
        out_ready_a[d] = 1'b1;
        vectors++;
        if (got != n_ops) begin
            miscompares++;
            $display("[TB] FAIL t5_result_count dut%0d: got %0d results expected %0d", d, got, n_ops);
        end
        extra = 1'b0;
        repeat (25) begin
            @(posedge clock); #1;
            if (out_valid_a[d] === 1'b1) extra = 1'b1;
        end
        vectors++;
        if (extra) begin
            miscompares++;
            $display("[TB] FAIL t5_duplicate dut%0d: got out_valid=1 after drain expected 0", d);
        end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] q, r; logic dz; logic [7:0] t; int lat;
        bit seen;
        @(posedge clock); #1;
        out_ready_a[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid_a[0] = 1'b1;
            dividend_a[0] = 16'($urandom);
            divisor_a[0]  = 8'($urandom_range(1, 255));
            in_tag_a[0]   = 8'(i);
            @(posedge clock); #1;
        end
        nreset = 1'b1;
        dividend_a[0] = 16'd77;
        divisor_a[0]  = 8'd7;
        @(posedge clock); #1;
        nreset = 1'b0;
        in_valid_a[0] = 1'b0;
        vectors++;
        if (out_valid_a[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL t6_valid_after_reset: got %b expected 0", out_valid_a[0]);
        end
        seen = 1'b0;
        repeat (30) begin
            @(posedge clock); #1;
            if (out_valid_a[0] === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL t6_stale_result: got out_valid=1 after reset expected 0");
        end
        run_op(0, 16'd9, 8'd3, 8'h5A, q, r, dz, t, lat);
        vectors++;
        if (q !== 16'd3 || r !== 16'd0 || dz !== 1'b0 || t !== 8'h5A || lat !== 18) begin
            miscompares++;
            $display("[TB] FAIL t6_first_op: got q=%0d r=%0d dz=%b tag=%h lat=%0d, expected q=3 r=0 dz=0 tag=5a lat=18",
                     $signed(q), $signed(r), dz, t, lat);
        end
    endtask

    initial begin
        test_reset();
        test_truncate();
        test_sign_round();
        test_extremes();
        test_div_zero();
        for (int d = 0; d < NDUT; d++) test_back_to_back(d, 40);
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
